// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over a 2^GATE_BITS-clock window
// and reports the count scaled into an NCO tuning word.
module freq_meter #(
    parameter int PHASE_INC_BITS = 40,
    parameter int GATE_BITS      = 20
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      sig_in,
    input  logic                      start,
    input  logic                      cont,
    output logic                      busy,
    output logic [PHASE_INC_BITS-1:0] phase_inc,
    output logic                      valid
);

    localparam int SHIFT = PHASE_INC_BITS - GATE_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q;
    logic [2:0]                sync_q;
    logic                      req_q;
    logic [GATE_BITS-1:0]      gate_cnt_q;
    logic [GATE_BITS-1:0]      edge_cnt_q;
    logic [PHASE_INC_BITS-1:0] phase_inc_q;
    logic                      valid_q;

    logic                      rise;
    logic [GATE_BITS-1:0]      edge_cnt_d;
    logic [PHASE_INC_BITS-1:0] phase_inc_d;

    // sync_q[1] is the second synchronizer stage, sync_q[2] the delayed copy.
    assign rise        = sync_q[1] & ~sync_q[2];
    assign edge_cnt_d  = edge_cnt_q + {{(GATE_BITS-1){1'b0}}, rise};
    assign phase_inc_d = {{SHIFT{1'b0}}, edge_cnt_d} << SHIFT;

    // The request is registered once in IDLE and acted on at the following edge,
    // so a start sampled at edge n opens the gate at edge n+1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            req_q       <= 1'b0;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            phase_inc_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], sig_in};
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_q) begin
                        state_q    <= GATE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                    end else begin
                        req_q <= start | cont;
                    end
                end
                GATE: begin
                    gate_cnt_q <= gate_cnt_q + {{(GATE_BITS-1){1'b0}}, 1'b1};
                    edge_cnt_q <= edge_cnt_d;
                    if (&gate_cnt_q) begin
                        state_q     <= DONE;
                        phase_inc_q <= phase_inc_d;
                        valid_q     <= 1'b1;
                    end
                end
                DONE: begin
                    if (cont) begin
                        state_q    <= GATE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign phase_inc = phase_inc_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: logs every sampled sig_in value and predicts
// each result by counting 0->1 transitions in the logged window.
module tb_freq_meter;

    localparam int PIB   = 40;
    localparam int GB    = 10;
    localparam int WIN   = 1 << GB;
    localparam int SHIFT = PIB - GB;

    logic           CLK    = 1'b0;
    logic           RST    = 1'b1;
    logic           sig_in = 1'b0;
    logic           start  = 1'b0;
    logic           cont   = 1'b0;
    logic           busy;
    logic           valid;
    logic [PIB-1:0] phase_inc;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int vcount = 0;
    logic log_q [0:65535];

    // stimulus source: 0 const0, 1 const1, 2 square wave, 3 toggle, 4 random, 5 NCO
    int             mode = 0;
    int             per  = 8;
    int             hi   = 4;
    int             ph   = 0;
    logic [PIB-1:0] nco_acc = '0;
    logic [PIB-1:0] nco_w   = '0;

    freq_meter #(.PHASE_INC_BITS(PIB), .GATE_BITS(GB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .sig_in   (sig_in),
        .start    (start),
        .cont     (cont),
        .busy     (busy),
        .phase_inc(phase_inc),
        .valid    (valid)
    );

    always #5 CLK = ~CLK;

    // cyc is the index of the next rising edge when read at a falling edge
    always @(posedge CLK) begin
        cyc         <= cyc + 1;
        log_q[cyc]  <= sig_in;
        vcount      <= vcount + (valid ? 1 : 0);
    end

    always @(negedge CLK) begin
        case (mode)
            0: sig_in = 1'b0;
            1: sig_in = 1'b1;
            2: begin
                sig_in = (ph < hi);
                ph     = (ph + 1 >= per) ? 0 : ph + 1;
            end
            3: sig_in = ~sig_in;
            4: sig_in = 1'($urandom_range(0, 1));
            default: begin
                nco_acc = nco_acc + nco_w;
                sig_in  = nco_acc[PIB-1];
            end
        endcase
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rising edges seen by the meter when start is sampled at edge n: the gate
    // covers input samples n .. n+WIN-1 (two-flop synchronizer latency).
    function automatic int model_edges(input int n);
        int c = 0;
        for (int j = n; j < n + WIN; j++)
            if (log_q[j] === 1'b1 && log_q[j-1] === 1'b0) c++;
        return c;
    endfunction

    task automatic pulse_start(output int n);
        @(negedge CLK);
        start = 1'b1;
        n     = cyc;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic measure(input string tag, input int n, output logic [PIB-1:0] pi);
        int vcyc = -1;
        pi = '0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            if (valid) begin
                vcyc = cyc;
                pi   = phase_inc;
                break;
            end
        end
        if (vcyc < 0) begin
            check({tag, "_timeout"}, 64'(valid), 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(vcyc - n), 64'(WIN + 2));
            check({tag, "_model"}, 64'(pi), 64'(model_edges(n)) << SHIFT);
        end
    endtask

    initial begin
        int             n;
        int             v0;
        logic [PIB-1:0] pi;
        logic [PIB-1:0] pi2;
        logic [PIB-1:0] w;

        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_phase", 64'(phase_inc), 64'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("idle_hold_busy", 64'(busy), 64'd0);

        // period 8 square wave
        mode = 2; per = 8; hi = 4;
        repeat (10) @(negedge CLK);
        pulse_start(n);
        repeat (5) @(negedge CLK);
        check("p8_busy_mid", 64'(busy), 64'd1);
        measure("p8", n, pi);
        check("p8_value", 64'(pi), 64'd128 << SHIFT);
        @(negedge CLK);
        check("p8_valid_width", 64'(valid), 64'd0);
        check("p8_busy_after", 64'(busy), 64'd0);

        // constant inputs
        for (int k = 0; k < 2; k++) begin
            mode = k;
            repeat (10) @(negedge CLK);
            v0 = vcount;
            pulse_start(n);
            measure(k == 0 ? "const0" : "const1", n, pi);
            check(k == 0 ? "const0_value" : "const1_value", 64'(pi), 64'd0);
            repeat (20) @(negedge CLK);
            check(k == 0 ? "const0_pulses" : "const1_pulses", 64'(vcount - v0), 64'd1);
        end

        // Nyquist
        mode = 3;
        repeat (10) @(negedge CLK);
        pulse_start(n);
        measure("nyq", n, pi);
        check("nyq_value", 64'(pi), 64'd512 << SHIFT);

        // random square waves and random bit stream
        for (int k = 0; k < 3; k++) begin
            per  = int'($urandom_range(3, 40));
            hi   = int'($urandom_range(1, per - 1));
            mode = 2;
            repeat (int'($urandom_range(5, 30))) @(negedge CLK);
            pulse_start(n);
            measure("rand_sq", n, pi);
        end
        mode = 4;
        repeat (10) @(negedge CLK);
        pulse_start(n);
        measure("rand_bits", n, pi);

        // continuous mode, period 16, stray starts during the gate
        mode = 2; per = 16; hi = 8;
        repeat (10) @(negedge CLK);
        v0 = vcount;
        @(negedge CLK);
        cont = 1'b1;
        n    = cyc;
        for (int k = 0; k < 4; k++) begin
            repeat (int'($urandom_range(20, 900))) @(negedge CLK);
            start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            if (k == 3) cont = 1'b0;
            measure("cont", n + (WIN + 1) * k, pi);
            check("cont_value", 64'(pi), 64'd64 << SHIFT);
        end
        repeat (1100) @(negedge CLK);
        check("cont_pulses", 64'(vcount - v0), 64'd4);
        check("cont_busy_after", 64'(busy), 64'd0);

        // reset in the middle of a gate
        mode = 2; per = 8; hi = 4;
        repeat (10) @(negedge CLK);
        pulse_start(n);
        repeat (500) @(negedge CLK);
        v0  = vcount;
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_phase", 64'(phase_inc), 64'd0);
        RST = 1'b0;
        repeat (700) @(negedge CLK);
        check("midrst_no_pulse", 64'(vcount - v0), 64'd0);
        check("midrst_phase_hold", 64'(phase_inc), 64'd0);
        pulse_start(n);
        measure("postrst", n, pi);
        check("postrst_value", 64'(pi), 64'd128 << SHIFT);

        // NCO loop: measure a preset word, then drive the NCO with the result
        for (int k = 0; k < 2; k++) begin
            w       = {2'b00, 6'($urandom_range(1, 63)), 32'($urandom)};
            nco_w   = w;
            mode    = 5;
            repeat (10) @(negedge CLK);
            pulse_start(n);
            measure("nco_open", n, pi);
            check("nco_open_err", 64'(((pi > w) ? pi - w : w - pi) <= (40'd1 << SHIFT)), 64'd1);
            nco_w = pi;
            repeat (10) @(negedge CLK);
            pulse_start(n);
            measure("nco_closed", n, pi2);
            check("nco_closed_err", 64'(((pi2 > w) ? pi2 - w : w - pi2) <= (40'd1 << SHIFT)), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
